// File: rtl/tdm_demux4_pkg.sv
// Shared constants, state encoding and slot-width helper for the TDM 4-channel receiver.
package tdm_pkg;

    localparam int CHANNELS_DEF   = 4;
    localparam int MISS_LIMIT_DEF = 2;
    localparam int MISS_W         = 4;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    function automatic int sel_width(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

    localparam int SEL_W_DEF = sel_width(CHANNELS_DEF);

endpackage

// File: rtl/tdm_demux4_if.sv
// Serial link inputs and demultiplexed frame outputs of the TDM receiver.
interface tdm_demux4_if
    import tdm_pkg::*;
#(
    parameter int CHANNELS = CHANNELS_DEF,
    parameter int SEL_W    = sel_width(CHANNELS)
) ();

    logic                valid_in;
    logic                serial_in;
    logic                frame_sync;
    logic [CHANNELS-1:0] out;
    logic                out_valid;
    logic [SEL_W-1:0]    select;
    logic                locked;
    logic                sync_err;

    modport master (
        output valid_in, serial_in, frame_sync,
        input  out, out_valid, select, locked, sync_err
    );

    modport slave (
        input  valid_in, serial_in, frame_sync,
        output out, out_valid, select, locked, sync_err
    );

endinterface

// File: rtl/tdm_demux4_slot_counter.sv
// Wrapping slot index: clear beats load-to-1, which beats the per-beat increment.
module tdm_slot_counter #(
    parameter int SEL_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load_one,
    input  logic             clr,
    output logic [SEL_W-1:0] slot,
    output logic             last
);

    logic [SEL_W-1:0] slot_r;

    // Slot register with clear / load-to-1 / wrapping increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_r <= {SEL_W{1'b0}};
        end else if (clr) begin
            slot_r <= {SEL_W{1'b0}};
        end else if (load_one) begin
            slot_r <= SEL_W'(1);
        end else if (en) begin
            slot_r <= slot_r + SEL_W'(1);
        end else begin
            slot_r <= slot_r;
        end
    end

    assign slot = slot_r;
    assign last = (slot_r == {SEL_W{1'b1}});

endmodule

// File: rtl/tdm_demux4.sv
// TDM receiver: aligns on slot-0 sync markers, flywheels over missed markers,
// and delivers each completed frame as a registered parallel word.
module tdm_demux4
    import tdm_pkg::*;
#(
    parameter int CHANNELS   = CHANNELS_DEF,
    parameter int SEL_W      = sel_width(CHANNELS),
    parameter int MISS_LIMIT = MISS_LIMIT_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    tdm_demux4_if.slave  bus
);

    localparam logic [MISS_W-1:0] MISS_LIM = MISS_W'(MISS_LIMIT);

    state_e              state_r, state_n;
    logic [CHANNELS-1:0] partial_r, partial_n;
    logic [MISS_W-1:0]   miss_cnt_r, miss_cnt_n;
    logic [CHANNELS-1:0] out_r, out_n;
    logic                out_valid_r, out_valid_n;
    logic                sync_err_r, sync_err_n;

    logic [SEL_W-1:0]    slot_s;
    logic                last_s;
    logic                cnt_inc_s, cnt_load_s, cnt_clr_s;
    logic [MISS_W-1:0]   miss_inc_s;

    tdm_slot_counter #(.SEL_W(SEL_W)) u_slot (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (cnt_inc_s),
        .load_one (cnt_load_s),
        .clr      (cnt_clr_s),
        .slot     (slot_s),
        .last     (last_s)
    );

    assign miss_inc_s = (miss_cnt_r >= MISS_LIM) ? miss_cnt_r : miss_cnt_r + 4'd1;

    // Frame alignment FSM and capture decisions for the current beat.
    always_comb begin
        state_n     = state_r;
        partial_n   = partial_r;
        miss_cnt_n  = miss_cnt_r;
        out_n       = out_r;
        out_valid_n = 1'b0;
        sync_err_n  = 1'b0;
        cnt_inc_s   = 1'b0;
        cnt_load_s  = 1'b0;
        cnt_clr_s   = 1'b0;
        if (bus.valid_in) begin
            case (state_r)
                HUNT: begin
                    if (bus.frame_sync) begin
                        partial_n    = {CHANNELS{1'b0}};
                        partial_n[0] = bus.serial_in;
                        cnt_load_s   = 1'b1;
                        miss_cnt_n   = 4'd0;
                        state_n      = LOCKED;
                    end else begin
                        state_n = HUNT;
                    end
                end
                LOCKED: begin
                    if (bus.frame_sync) begin
                        // Early sync truncates the current frame; a slot-0 sync just restarts it.
                        sync_err_n   = (slot_s != {SEL_W{1'b0}});
                        partial_n    = {CHANNELS{1'b0}};
                        partial_n[0] = bus.serial_in;
                        cnt_load_s   = 1'b1;
                        miss_cnt_n   = 4'd0;
                    end else if (slot_s == {SEL_W{1'b0}}) begin
                        sync_err_n = 1'b1;
                        miss_cnt_n = miss_inc_s;
                        if (miss_inc_s == MISS_LIM) begin
                            state_n   = HUNT;
                            partial_n = {CHANNELS{1'b0}};
                            cnt_clr_s = 1'b1;
                        end else begin
                            partial_n[0] = bus.serial_in;
                            cnt_load_s   = 1'b1;
                        end
                    end else if (!last_s) begin
                        partial_n[slot_s] = bus.serial_in;
                        cnt_inc_s         = 1'b1;
                    end else begin
                        out_n       = {bus.serial_in, partial_r[CHANNELS-2:0]};
                        out_valid_n = 1'b1;
                        cnt_inc_s   = 1'b1;
                    end
                end
                default: begin
                    state_n   = HUNT;
                    cnt_clr_s = 1'b1;
                end
            endcase
        end else begin
            state_n = state_r;
        end
    end

    // State, capture and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= HUNT;
            partial_r   <= {CHANNELS{1'b0}};
            miss_cnt_r  <= 4'd0;
            out_r       <= {CHANNELS{1'b0}};
            out_valid_r <= 1'b0;
            sync_err_r  <= 1'b0;
        end else begin
            state_r     <= state_n;
            partial_r   <= partial_n;
            miss_cnt_r  <= miss_cnt_n;
            out_r       <= out_n;
            out_valid_r <= out_valid_n;
            sync_err_r  <= sync_err_n;
        end
    end

    assign bus.out       = out_r;
    assign bus.out_valid = out_valid_r;
    assign bus.select    = slot_s;
    assign bus.locked    = (state_r == LOCKED);
    assign bus.sync_err  = sync_err_r;

endmodule
